// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        IACC,
        DACC,
        IRESP,
        DRESP
    } arbState;

    localparam logic [31:0] ARB_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/memory_arbiter.sv
// Two-requester (instruction/data) arbiter onto one shared memory port, alternating priority on contention.
// Latency: request->strobe 1 cycle, mem_ack->ready pulse 1 cycle; requesters hold requests until their ready pulse.
// Backpressure: strobes stay high until mem_ack; ARB_TIMEOUT_EN adds a watchdog that completes stalled accesses.
module memory_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              imemRen,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmmRen,
    input  logic              dmmWen,
    input  logic [ADDR_W-1:0] dmmaddr,
    input  logic [DATA_W-1:0] dmmstore,
    output logic              i_ready,
    output logic              d_ready,
    output logic [DATA_W-1:0] imemload,
    output logic [DATA_W-1:0] dmmload,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              arb_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("memory_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arbState           state;
    arbState           state_nxt;
    logic              last_grant;   // 1 = data side won the most recent grant
    logic              acc_wr;
    logic              d_req;
    logic              grant_d;
    logic              grant_i;
    logic              timeout;
    logic [DATA_W-1:0] err_load;

    assign d_req   = dmmRen | dmmWen;
    assign grant_d = d_req & (~imemRen | ~last_grant);
    assign grant_i = imemRen & ~grant_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = DACC;
                end else if (grant_i) begin
                    state_nxt = IACC;
                end
            end
            IACC:    if (mem_ack || timeout) state_nxt = IRESP;
            DACC:    if (mem_ack || timeout) state_nxt = DRESP;
            IRESP:   state_nxt = IDLE;
            DRESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        case (state)
            IACC: mem_ren = 1'b1;
            DACC: begin
                mem_ren = ~acc_wr;
                mem_wen = acc_wr;
            end
            IRESP:   i_ready = 1'b1;
            DRESP:   d_ready = 1'b1;
            default: ;
        endcase
    end

    // Access parameters are frozen at grant so the memory sees stable mem_* for the whole access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant <= 1'b0;
            acc_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            imemload   <= '0;
            dmmload    <= '0;
        end else begin
            if (state == IDLE) begin
                if (grant_d) begin
                    last_grant <= 1'b1;
                    acc_wr     <= dmmWen;
                    mem_addr   <= dmmaddr;
                    mem_wdata  <= dmmstore;
                end else if (grant_i) begin
                    last_grant <= 1'b0;
                    acc_wr     <= 1'b0;
                    mem_addr   <= imemaddr;
                end
            end
            if (state == IACC) begin
                if (mem_ack) begin
                    imemload <= mem_rdata;
                end else if (timeout) begin
                    imemload <= err_load;
                end
            end
            if (state == DACC) begin
                if (mem_ack) begin
                    if (!acc_wr) begin
                        dmmload <= mem_rdata;
                    end
                end else if (timeout) begin
                    dmmload <= err_load;
                end
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0] tcnt;
    logic              arb_err_q;
    logic              in_acc;

    assign in_acc   = (state == IACC) || (state == DACC);
    assign timeout  = in_acc && (tcnt == TCNT_LAST);
    assign err_load = DATA_W'(ARB_ERR_DATA);
    assign arb_err  = arb_err_q;

    // A same-cycle mem_ack beats the watchdog, so the error flag only sets on a true stall.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt      <= '0;
            arb_err_q <= 1'b0;
        end else if (in_acc) begin
            tcnt <= tcnt + TCNT_W'(1);
            if (timeout && !mem_ack) begin
                arb_err_q <= 1'b1;
            end
        end else begin
            tcnt <= '0;
        end
    end
`else
    assign timeout  = 1'b0;
    assign err_load = '0;
    assign arb_err  = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboarded bench for memory_arbiter: a memory responder model, access/ready monitors and per-scenario tasks.
module tb_memory_arbiter;
    import arb_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct packed {
        logic        is_d;
        logic        chk;
        logic [31:0] data;
    } rdy_t;

    logic        tb_clk = 1'b0;
    logic        rst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic        dmm_ren;
    logic        dmm_wen;
    logic [31:0] dmm_addr;
    logic [31:0] dmm_store;
    logic        i_ready;
    logic        d_ready;
    logic [31:0] imem_load;
    logic [31:0] dmm_load;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        arb_err;

    int tests_run    = 0;
    int tests_failed = 0;

    acc_t exp_acc[$];
    rdy_t exp_rdy[$];

    always #5 tb_clk = ~tb_clk;

    memory_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK       (tb_clk),
        .RST       (rst),
        .imemRen   (imem_ren),
        .imemaddr  (imem_addr),
        .dmmRen    (dmm_ren),
        .dmmWen    (dmm_wen),
        .dmmaddr   (dmm_addr),
        .dmmstore  (dmm_store),
        .i_ready   (i_ready),
        .d_ready   (d_ready),
        .imemload  (imem_load),
        .dmmload   (dmm_load),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .arb_err   (arb_err)
    );

    // Memory model: read data is a keyed function of the address; ack after ack_delay strobe cycles (0 = never).
    int          ack_delay = 0;
    int          rcnt      = 0;
    logic        resp_ack  = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] rdata_key = 32'h0;

    assign mem_ack   = resp_ack | stray_ack;
    assign mem_rdata = rdata_key ^ mem_addr;

    always begin
        @(posedge tb_clk);
        #1;
        if ((mem_ren || mem_wen) && !resp_ack) begin
            rcnt++;
            if (ack_delay != 0 && rcnt == ack_delay) resp_ack = 1'b1;
        end else begin
            resp_ack = 1'b0;
            rcnt     = 0;
        end
    end

    logic mon_en      = 1'b0;
    logic prev_strobe = 1'b0;
    logic prev_i      = 1'b0;
    logic prev_d      = 1'b0;
    acc_t cur_acc     = '0;
    rdy_t cur_rdy     = '0;

    always begin
        @(posedge tb_clk);
        #1;
        if (mon_en) begin
            if (mem_ren || mem_wen) begin
                tests_run++;
                if (!prev_strobe) begin
                    if (exp_acc.size() == 0) begin
                        tests_failed++;
                        $display("FAIL acc_start: unexpected access wen=%b addr=%h", mem_wen, mem_addr);
                    end else begin
                        cur_acc = exp_acc.pop_front();
                        if (mem_wen !== cur_acc.wr || mem_ren !== !cur_acc.wr || mem_addr !== cur_acc.addr ||
                            (cur_acc.wr && mem_wdata !== cur_acc.wdata)) begin
                            tests_failed++;
                            $display("FAIL acc_start: got ren=%b wen=%b addr=%h wdata=%h, expected wr=%b addr=%h wdata=%h",
                                     mem_ren, mem_wen, mem_addr, mem_wdata, cur_acc.wr, cur_acc.addr, cur_acc.wdata);
                        end
                    end
                end else if (mem_addr !== cur_acc.addr || mem_wen !== cur_acc.wr || mem_ren !== !cur_acc.wr) begin
                    tests_failed++;
                    $display("FAIL acc_stable: got wen=%b addr=%h, expected wr=%b addr=%h",
                             mem_wen, mem_addr, cur_acc.wr, cur_acc.addr);
                end
            end
            if (i_ready || d_ready) begin
                tests_run++;
                if (exp_rdy.size() == 0) begin
                    tests_failed++;
                    $display("FAIL ready: unexpected pulse i_ready=%b d_ready=%b", i_ready, d_ready);
                end else begin
                    cur_rdy = exp_rdy.pop_front();
                    if ((i_ready && d_ready) || d_ready !== cur_rdy.is_d ||
                        (cur_rdy.chk && ((cur_rdy.is_d ? dmm_load : imem_load) !== cur_rdy.data))) begin
                        tests_failed++;
                        $display("FAIL ready: got i=%b d=%b imemload=%h dmmload=%h, expected is_d=%b data=%h",
                                 i_ready, d_ready, imem_load, dmm_load, cur_rdy.is_d, cur_rdy.data);
                    end
                end
                tests_run++;
                if ((i_ready && prev_i) || (d_ready && prev_d)) begin
                    tests_failed++;
                    $display("FAIL ready_len: got pulse longer than 1 cycle, expected 1 cycle");
                end
            end
        end
        prev_strobe = mem_ren | mem_wen;
        prev_i      = i_ready;
        prev_d      = d_ready;
    end

    function automatic acc_t mk_acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        acc_t a;
        a.wr    = wr;
        a.addr  = addr;
        a.wdata = wdata;
        return a;
    endfunction

    function automatic rdy_t mk_rdy(input logic is_d, input logic chk, input logic [31:0] data);
        rdy_t r;
        r.is_d = is_d;
        r.chk  = chk;
        r.data = data;
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge tb_clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: got ren=%b wen=%b, expected 0 0", mem_ren, mem_wen);
        end
        tests_run++;
        if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got i=%b d=%b, expected 0 0", i_ready, d_ready);
        end
        tests_run++;
        if (imem_load !== 32'h0 || dmm_load !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_loads: got %h %h, expected 0 0", imem_load, dmm_load);
        end
        tests_run++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_bus: got addr=%h wdata=%h, expected 0 0", mem_addr, mem_wdata);
        end
        tests_run++;
        if (arb_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_arb_err: got %b, expected 0", arb_err);
        end
        idle_cycles(2);
        tests_run++;
        if (mem_ren !== 1'b0 || mem_wen !== 1'b0 || i_ready !== 1'b0 || d_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_req: got ren=%b wen=%b i=%b d=%b, expected all 0", mem_ren, mem_wen, i_ready, d_ready);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_contention();
        int         nrdy    = 0;
        int         d_at    = -1;
        int         i_start = -1;
        logic [3:0] seq     = 4'h0;
        idle_cycles(2);
        ack_delay = 2;
        rdata_key = 32'h13579BDF;
        exp_acc.push_back(mk_acc(1'b1, 32'h00010001, 32'hABCDABCD));
        exp_acc.push_back(mk_acc(1'b0, 32'h00000400, 32'h0));
        exp_rdy.push_back(mk_rdy(1'b1, 1'b0, 32'h0));
        exp_rdy.push_back(mk_rdy(1'b0, 1'b1, 32'h13579BDF ^ 32'h00000400));
        dmm_addr  = 32'h00010001;
        dmm_store = 32'hABCDABCD;
        dmm_wen   = 1'b1;
        dmm_ren   = 1'b1;
        imem_addr = 32'h00000400;
        imem_ren  = 1'b1;
        for (int c = 1; c <= 60 && nrdy < 2; c++) begin
            @(posedge tb_clk);
            #1;
            if (c == 1) begin
                tests_run++;
                if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_wdata !== 32'hABCDABCD) begin
                    tests_failed++;
                    $display("FAIL contention_first: got wen=%b ren=%b wdata=%h, expected 1 0 abcdabcd",
                             mem_wen, mem_ren, mem_wdata);
                end
            end
            if (d_at >= 0 && mem_ren && i_start < 0) i_start = c;
            if (d_ready) begin
                seq[nrdy] = 1'b1;
                nrdy++;
                d_at    = c;
                dmm_wen = 1'b0;
                dmm_ren = 1'b0;
            end
            if (i_ready) begin
                seq[nrdy] = 1'b0;
                nrdy++;
                imem_ren = 1'b0;
            end
        end
        tests_run++;
        if (nrdy != 2 || seq[1:0] !== 2'b01) begin
            tests_failed++;
            $display("FAIL contention_order: got %0d readies seq=%b, expected 2 readies D then I", nrdy, seq[1:0]);
        end
        tests_run++;
        if (i_start != d_at + 2) begin
            tests_failed++;
            $display("FAIL contention_regrant: got I grant at %0d, expected %0d", i_start, d_at + 2);
        end
        dmm_wen  = 1'b0;
        dmm_ren  = 1'b0;
        imem_ren = 1'b0;
    endtask

    task automatic test_inst_read();
        int n_ren  = 0;
        int first  = -1;
        int rdy_at = -1;
        idle_cycles(2);
        ack_delay = 3;
        rdata_key = 32'h00A00093 ^ 32'h12341234;
        exp_acc.push_back(mk_acc(1'b0, 32'h12341234, 32'h0));
        exp_rdy.push_back(mk_rdy(1'b0, 1'b1, 32'h00A00093));
        imem_addr = 32'h12341234;
        imem_ren  = 1'b1;
        for (int c = 1; c <= 40 && rdy_at < 0; c++) begin
            @(posedge tb_clk);
            #1;
            if (mem_ren) begin
                n_ren++;
                if (first < 0) first = c;
            end
            if (i_ready) begin
                rdy_at   = c;
                imem_ren = 1'b0;
            end
        end
        imem_ren = 1'b0;
        tests_run++;
        if (first != 1 || n_ren != 3) begin
            tests_failed++;
            $display("FAIL inst_read_strobe: got first=%0d cycles=%0d, expected first=1 cycles=3", first, n_ren);
        end
        tests_run++;
        if (rdy_at != 4) begin
            tests_failed++;
            $display("FAIL inst_read_latency: got ready at %0d, expected 4", rdy_at);
        end
        idle_cycles(3);
        tests_run++;
        if (imem_load !== 32'h00A00093 || i_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL inst_read_hold: got imemload=%h i_ready=%b, expected 00a00093 0", imem_load, i_ready);
        end
    endtask

    task automatic test_back_to_back();
        int         nrdy = 0;
        logic [3:0] seq  = 4'h0;
        idle_cycles(2);
        ack_delay = 1;
        rdata_key = 32'hC0FFEE00;
        for (int k = 0; k < 2; k++) begin
            exp_acc.push_back(mk_acc(1'b0, 32'h00002000, 32'h0));
            exp_acc.push_back(mk_acc(1'b0, 32'h00001000, 32'h0));
            exp_rdy.push_back(mk_rdy(1'b1, 1'b1, 32'hC0FFEE00 ^ 32'h00002000));
            exp_rdy.push_back(mk_rdy(1'b0, 1'b1, 32'hC0FFEE00 ^ 32'h00001000));
        end
        imem_addr = 32'h00001000;
        dmm_addr  = 32'h00002000;
        imem_ren  = 1'b1;
        dmm_ren   = 1'b1;
        for (int c = 1; c <= 80 && nrdy < 4; c++) begin
            @(posedge tb_clk);
            #1;
            if (d_ready) begin
                seq[nrdy] = 1'b1;
                nrdy++;
            end
            if (i_ready && nrdy < 4) begin
                seq[nrdy] = 1'b0;
                nrdy++;
            end
        end
        imem_ren = 1'b0;
        dmm_ren  = 1'b0;
        tests_run++;
        if (nrdy != 4 || seq !== 4'b0101) begin
            tests_failed++;
            $display("FAIL back_to_back: got %0d readies seq=%b, expected 4 readies seq=0101 (D,I,D,I)", nrdy, seq);
        end
    endtask

    task automatic test_reset_mid_access();
        logic seen = 1'b0;
        idle_cycles(2);
        ack_delay = 0;
        exp_acc.push_back(mk_acc(1'b1, 32'h00000300, 32'h5555AAAA));
        dmm_addr  = 32'h00000300;
        dmm_store = 32'h5555AAAA;
        dmm_wen   = 1'b1;
        repeat (3) @(posedge tb_clk);
        #1;
        tests_run++;
        if (mem_wen !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_pre: got wen=%b, expected 1", mem_wen);
        end
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        tests_run++;
        if (mem_wen !== 1'b0 || mem_ren !== 1'b0 || d_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_strobe: got wen=%b ren=%b d=%b, expected 0 0 0", mem_wen, mem_ren, d_ready);
        end
        tests_run++;
        if (imem_load !== 32'h0 || dmm_load !== 32'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_loads: got %h %h, expected 0 0", imem_load, dmm_load);
        end
        rst     = 1'b0;
        dmm_wen = 1'b0;
        repeat (5) begin
            @(posedge tb_clk);
            #1;
            if (d_ready || i_ready || mem_ren || mem_wen) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_after: got activity after reset, expected idle");
        end
    endtask

    task automatic test_stray_ack();
        logic seen = 1'b0;
        idle_cycles(1);
        rdata_key = 32'h77777777;
        stray_ack = 1'b1;
        @(posedge tb_clk);
        #1;
        stray_ack = 1'b0;
        repeat (4) begin
            @(posedge tb_clk);
            #1;
            if (d_ready || i_ready || mem_ren || mem_wen) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0 || imem_load !== 32'h0 || dmm_load !== 32'h0) begin
            tests_failed++;
            $display("FAIL stray_ack: got activity=%b imemload=%h dmmload=%h, expected 0 0 0", seen, imem_load, dmm_load);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic run_data_read(input logic [31:0] addr, output int n_ren, output int rdy_at);
        n_ren   = 0;
        rdy_at  = -1;
        dmm_addr = addr;
        dmm_ren  = 1'b1;
        for (int c = 1; c <= 40 && rdy_at < 0; c++) begin
            @(posedge tb_clk);
            #1;
            if (mem_ren) n_ren++;
            if (d_ready) begin
                rdy_at  = c;
                dmm_ren = 1'b0;
            end
        end
        dmm_ren = 1'b0;
    endtask

    task automatic test_timeout();
        int n_ren;
        int rdy_at;
        int irdy = -1;
        idle_cycles(2);
        ack_delay = 0;
        exp_acc.push_back(mk_acc(1'b0, 32'h00000500, 32'h0));
        exp_rdy.push_back(mk_rdy(1'b1, 1'b1, 32'hDEADBEEF));
        run_data_read(32'h00000500, n_ren, rdy_at);
        tests_run++;
        if (n_ren != 8 || rdy_at != 9 || arb_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_fire: got strobe=%0d ready_at=%0d err=%b, expected 8 9 1", n_ren, rdy_at, arb_err);
        end
        idle_cycles(2);
        ack_delay = 2;
        rdata_key = 32'h0BADF00D;
        exp_acc.push_back(mk_acc(1'b0, 32'h00000600, 32'h0));
        exp_rdy.push_back(mk_rdy(1'b0, 1'b1, 32'h0BADF00D ^ 32'h00000600));
        imem_addr = 32'h00000600;
        imem_ren  = 1'b1;
        for (int c = 1; c <= 40 && irdy < 0; c++) begin
            @(posedge tb_clk);
            #1;
            if (i_ready) begin
                irdy     = c;
                imem_ren = 1'b0;
            end
        end
        imem_ren = 1'b0;
        tests_run++;
        if (irdy < 0 || arb_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_sticky: got ready_at=%0d err=%b, expected ready and err=1", irdy, arb_err);
        end
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if (arb_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear: got err=%b, expected 0", arb_err);
        end
        idle_cycles(2);
        ack_delay = 8;
        exp_acc.push_back(mk_acc(1'b0, 32'h00000700, 32'h0));
        exp_rdy.push_back(mk_rdy(1'b1, 1'b1, 32'h0BADF00D ^ 32'h00000700));
        run_data_read(32'h00000700, n_ren, rdy_at);
        tests_run++;
        if (n_ren != 8 || rdy_at != 9 || arb_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_ack_wins: got strobe=%0d ready_at=%0d err=%b, expected 8 9 0", n_ren, rdy_at, arb_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        int   n_ren  = 0;
        int   rdy_at = -1;
        logic early  = 1'b0;
        idle_cycles(2);
        ack_delay = 0;
        rdata_key = 32'h2468ACE0;
        exp_acc.push_back(mk_acc(1'b0, 32'h00000500, 32'h0));
        exp_rdy.push_back(mk_rdy(1'b1, 1'b1, 32'h2468ACE0 ^ 32'h00000500));
        dmm_addr = 32'h00000500;
        dmm_ren  = 1'b1;
        repeat (30) begin
            @(posedge tb_clk);
            #1;
            if (mem_ren) n_ren++;
            if (d_ready || arb_err) early = 1'b1;
        end
        tests_run++;
        if (n_ren != 30 || early !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_timeout_wait: got strobe=%0d early_ready_or_err=%b, expected 30 0", n_ren, early);
        end
        stray_ack = 1'b1;
        for (int c = 1; c <= 5 && rdy_at < 0; c++) begin
            @(posedge tb_clk);
            #1;
            stray_ack = 1'b0;
            if (d_ready) begin
                rdy_at  = c;
                dmm_ren = 1'b0;
            end
        end
        stray_ack = 1'b0;
        dmm_ren   = 1'b0;
        tests_run++;
        if (rdy_at != 1 || arb_err !== 1'b0 || dmm_load === ARB_ERR_DATA) begin
            tests_failed++;
            $display("FAIL no_timeout_done: got ready_at=%0d err=%b dmmload=%h, expected 1 0 non-error data",
                     rdy_at, arb_err, dmm_load);
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        imem_ren  = 1'b0;
        imem_addr = 32'h0;
        dmm_ren   = 1'b0;
        dmm_wen   = 1'b0;
        dmm_addr  = 32'h0;
        dmm_store = 32'h0;
        test_reset();
        test_contention();
        test_inst_read();
        test_back_to_back();
        test_reset_mid_access();
        test_stray_ack();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        idle_cycles(4);
        tests_run++;
        if (exp_acc.size() != 0 || exp_rdy.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d accesses and %0d readies outstanding, expected 0 0",
                     exp_acc.size(), exp_rdy.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles (used only under ARB_TIMEOUT_EN).
REQ-004 SHALL have port CLK, input, 1, single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port RST, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port imemRen, input, 1, instruction read request, held until i_ready.
REQ-007 SHALL have port imemaddr, input, ADDR_W, instruction address.
REQ-008 SHALL have port dmmRen, input, 1, data read request, held until d_ready.
REQ-009 SHALL have port dmmWen, input, 1, data write request, held until d_ready.
REQ-010 SHALL have port dmmaddr, input, ADDR_W, data address.
REQ-011 SHALL have port dmmstore, input, DATA_W, data write value.
REQ-012 SHALL have port i_ready, output, 1, one-cycle instruction completion pulse.
REQ-013 SHALL have port d_ready, output, 1, one-cycle data completion pulse.
REQ-014 SHALL have port imemload, output, DATA_W, fetched instruction; valid while i_ready is high.
REQ-015 SHALL have port dmmload, output, DATA_W, loaded data; valid while d_ready is high.
REQ-016 SHALL have port mem_ren, output, 1, shared-memory read strobe.
REQ-017 SHALL have port mem_wen, output, 1, shared-memory write strobe.
REQ-018 SHALL have port mem_addr, output, ADDR_W, shared-memory address.
REQ-019 SHALL have port mem_wdata, output, DATA_W, shared-memory write data.
REQ-020 SHALL have port mem_rdata, input, DATA_W, shared-memory read data; valid with mem_ack.
REQ-021 SHALL have port mem_ack, input, 1, shared-memory completion pulse.
REQ-022 SHALL have port arb_err, output, 1, sticky timeout flag.

Function
REQ-023 SHALL implement an FSM with states IDLE, IACC, DACC, IRESP, DRESP.
REQ-024 In IDLE, SHALL grant on the next edge: request pending -> IACC or DACC; none pending -> stay in IDLE.
REQ-025 When both are pending in IDLE, SHALL grant the side not granted last (last_grant bit, updated on each grant).
REQ-026 SHALL latch address, write data and read/write type into registers at grant; mem_* outputs SHALL be driven from these registers and stay stable for the whole access.
REQ-027 dmmWen=1 SHALL make a data access a write; dmmWen takes precedence when dmmRen=1 in the same cycle.
REQ-028 In IACC/DACC, SHALL drive mem_ren (reads) or mem_wen (writes) high until mem_ack is sampled high.
REQ-029 On mem_ack, SHALL capture mem_rdata into imemload/dmmload (reads only), deassert the strobe and move to IRESP/DRESP.
REQ-030 In IRESP/DRESP, SHALL assert i_ready/d_ready for exactly one cycle, grant nothing, and return to IDLE.
REQ-031 Minimum latency SHALL be: request -> grant 1 cycle, ack -> ready 1 cycle.
REQ-032 SHALL ignore mem_ack when in IDLE or RESP.
REQ-033 imemload and dmmload SHALL hold their last captured value between accesses.

Reset
REQ-034 When RST is high at an edge, SHALL force state IDLE, last_grant=instruction, all strobes/readies 0, imemload/dmmload/mem_addr/mem_wdata 0, arb_err 0, timeout counter 0.
REQ-035 Reset mid-access SHALL abandon the access with no ready pulse; strobes SHALL be low from the next cycle.

Configuration
REQ-036 With ARB_TIMEOUT_EN defined, SHALL count cycles spent in IACC/DACC; on reaching TIMEOUT_CYCLES without mem_ack, SHALL go to RESP with load value 32'hDEADBEEF and set arb_err (cleared only by RST).
REQ-037 mem_ack in the same cycle as timeout SHALL win: normal completion, no error.
REQ-038 Without ARB_TIMEOUT_EN, SHALL have no counter, tie arb_err to 0, and wait indefinitely for mem_ack.

Structure
REQ-039 Package arb_pkg SHALL hold the arbState enum (IDLE, IACC, DACC, IRESP, DRESP) and the constant ARB_ERR_DATA=32'hDEADBEEF.
REQ-040 The design SHALL be a single module; the FSM plus datapath registers need no sub-module.

Verification
REQ-041 RST=1 for 2 cycles, then RST=0 -> all outputs 0, state IDLE.
REQ-042 imemRen=1, imemaddr=32'h12341234, mem_ack after 3 cycles with rdata 32'h00A00093 -> mem_ren high 3 cycles at that address, then i_ready pulses 1 cycle with imemload=32'h00A00093.
REQ-043 imemRen and dmmWen asserted together after reset, dmmaddr=32'h00010001, dmmstore=32'hABCDABCD -> data granted first (mem_wen, mem_wdata=32'hABCDABCD); after d_ready, instruction granted next.
REQ-044 Two back-to-back contended rounds -> grants alternate D, I, D, I; no ready pulse lasts longer than one cycle.
REQ-045 RST asserted while in DACC -> no d_ready, mem_wen low next cycle, state IDLE.
REQ-046 With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no mem_ack -> d_ready after 8 cycles with dmmload=32'hDEADBEEF, arb_err=1 held until RST; ack on cycle 8 -> arb_err stays 0.
